// File: rtl/line_drawer.sv
// Bresenham line rasteriser: takes an endpoint pair on a start/ready handshake
// and emits one framebuffer write per pixel over a valid/ready handshake.
module line_drawer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] fb_x,
  output logic [Y_WIDTH-1:0] fb_y,
  output logic               fb_write,
  input  logic               fb_ready
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // INIT  | endpoints latched, stepping terms computed
  // PLOT  | pixel write offered, advance on accept
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] PLOT = 2'd2;

  localparam int D_WIDTH = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

  logic [1:0]                state;
  logic [X_WIDTH-1:0]        x1_q, x2_q, cur_x;
  logic [Y_WIDTH-1:0]        y1_q, y2_q, cur_y;
  logic signed [D_WIDTH-1:0] dx, dy, err;
  logic                      sx_neg, sy_neg;

  logic signed [D_WIDTH-1:0] x1_s, x2_s, y1_s, y2_s, diff_x, diff_y, abs_x, abs_y;
  logic signed [D_WIDTH:0]   e2, dx_e, dy_e;
  logic                      step_x, step_y, at_end, accept;
  logic signed [D_WIDTH-1:0] err_next;

  assign x1_s   = signed'(D_WIDTH'(x1_q));
  assign x2_s   = signed'(D_WIDTH'(x2_q));
  assign y1_s   = signed'(D_WIDTH'(y1_q));
  assign y2_s   = signed'(D_WIDTH'(y2_q));
  assign diff_x = x2_s - x1_s;
  assign diff_y = y2_s - y1_s;
  assign abs_x  = diff_x[D_WIDTH-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[D_WIDTH-1] ? -diff_y : diff_y;

  // One extra bit on e2 so doubling err can never wrap.
  assign e2     = signed'({err, 1'b0});
  assign dx_e   = signed'({dx[D_WIDTH-1], dx});
  assign dy_e   = signed'({dy[D_WIDTH-1], dy});
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign err_next = err + (step_x ? dy : D_WIDTH'(0)) + (step_y ? dx : D_WIDTH'(0));

  assign at_end   = (cur_x == x2_q) && (cur_y == y2_q);
  assign accept   = (state == PLOT) && fb_ready;
  assign ready    = (state == IDLE);
  assign fb_write = (state == PLOT);
  assign fb_x     = cur_x;
  assign fb_y     = cur_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x1_q   <= '0;
      y1_q   <= '0;
      x2_q   <= '0;
      y2_q   <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x1_q  <= x1;
            y1_q  <= y1;
            x2_q  <= x2;
            y2_q  <= y2;
            state <= INIT;
          end
        end
        INIT: begin
          dx     <= abs_x;
          dy     <= -abs_y;
          err    <= abs_x - abs_y;
          sx_neg <= !(x1_q < x2_q);
          sy_neg <= !(y1_q < y2_q);
          cur_x  <= x1_q;
          cur_y  <= y1_q;
          state  <= PLOT;
        end
        PLOT: begin
          if (accept) begin
            if (at_end) begin
              state <= IDLE;
            end else begin
              err <= err_next;
              if (step_x) cur_x <= cur_x + (sx_neg ? {X_WIDTH{1'b1}} : X_WIDTH'(1));
              if (step_y) cur_y <= cur_y + (sy_neg ? {Y_WIDTH{1'b1}} : Y_WIDTH'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: per-scenario tasks with inline checks.
module tb_line_drawer;

  logic       clk = 1'b0;
  logic       rst_n, start, ready, fb_write, fb_ready;
  logic [9:0] x1, x2, fb_x;
  logic [8:0] y1, y2, fb_y;

  int total = 0;
  int bad   = 0;

  int wq_x[$], wq_y[$], ex_x[$], ex_y[$];
  int first_cyc, done_cyc, stall_bad, oob;
  bit timed_out;

  line_drawer #(.HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .fb_x(fb_x), .fb_y(fb_y), .fb_write(fb_write), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  // Reference Bresenham stepping in plain integers.
  task automatic model(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, cx, cy;
    ex_x.delete(); ex_y.delete();
    dx = (bx > ax) ? bx - ax : ax - bx;
    dy = (by > ay) ? ay - by : by - ay;
    sx = (ax < bx) ? 1 : -1;
    sy = (ay < by) ? 1 : -1;
    err = dx + dy; cx = ax; cy = ay;
    for (int n = 0; n < 2000; n++) begin
      ex_x.push_back(cx); ex_y.push_back(cy);
      if (cx == bx && cy == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  // Called at a negedge with ready=1; returns at the negedge of the INIT cycle.
  task automatic start_line(input int ax, input int ay, input int bx, input int by);
    x1 = 10'(ax); y1 = 9'(ay); x2 = 10'(bx); y2 = 9'(by);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x1 = 10'd999; y1 = 9'd511; x2 = 10'd999; y2 = 9'd511;
  endtask

  // Drives fb_ready and records accepted writes until ready returns.
  task automatic collect(input int mode, input int budget, input int pulse_at);
    logic pend;
    int px, py;
    wq_x.delete(); wq_y.delete();
    first_cyc = -1; done_cyc = -1; stall_bad = 0; oob = 0; timed_out = 1'b1;
    pend = 1'b0; px = 0; py = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pend && (fb_write !== 1'b1 || int'(fb_x) != px || int'(fb_y) != py)) stall_bad++;
      if (ready === 1'b1 && wq_x.size() > 0) begin
        done_cyc = c; timed_out = 1'b0;
        break;
      end
      if (c == pulse_at) begin
        start = 1'b1; x1 = 10'd100; y1 = 9'd100; x2 = 10'd200; y2 = 9'd50;
      end else begin
        start = 1'b0;
      end
      fb_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (fb_write === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        if (fb_x > 10'd639 || fb_y > 9'd479) oob++;
        if (fb_ready) begin wq_x.push_back(int'(fb_x)); wq_y.push_back(int'(fb_y)); end
        pend = !fb_ready; px = int'(fb_x); py = int'(fb_y);
      end else begin
        pend = 1'b0;
      end
    end
    start = 1'b0;
    fb_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; fb_ready = 1'b1;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    #12;
    total++;
    if (ready !== 1'b1 || fb_write !== 1'b0 || fb_x !== 10'd0 || fb_y !== 9'd0) begin
      bad++;
      $display("FAIL reset_state: ready=%b fb_write=%b fb_x=%0d fb_y=%0d, want 1 0 0 0", ready, fb_write, fb_x, fb_y);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    start_line(5, 7, 5, 7);
    total++;
    if (ready !== 1'b0 || fb_write !== 1'b0) begin
      bad++; $display("FAIL single_init: ready=%b fb_write=%b, want 0 0", ready, fb_write);
    end
    collect(0, 20, -1);
    total++;
    if (timed_out || wq_x.size() != 1 || first_cyc != 0 || done_cyc != 1) begin
      bad++; $display("FAIL single_count: writes=%0d first=%0d done=%0d to=%0b, want 1 0 1 0", wq_x.size(), first_cyc, done_cyc, timed_out);
    end else begin
      total++;
      if (wq_x[0] != 5 || wq_y[0] != 7) begin
        bad++; $display("FAIL single_pixel: got (%0d,%0d), want (5,7)", wq_x[0], wq_y[0]);
      end
    end
  endtask

  task automatic test_horizontal;
    ex_x = '{10, 9, 8, 7, 6}; ex_y = '{3, 3, 3, 3, 3};
    start_line(10, 3, 6, 3);
    collect(0, 30, -1);
    total++;
    if (timed_out || wq_x.size() != 5 || done_cyc != 5) begin
      bad++; $display("FAIL horiz_count: writes=%0d done=%0d to=%0b, want 5 5 0", wq_x.size(), done_cyc, timed_out);
    end
    for (int i = 0; i < 5 && i < wq_x.size(); i++) begin
      total++;
      if (wq_x[i] != ex_x[i] || wq_y[i] != ex_y[i]) begin
        bad++; $display("FAIL horiz_pix%0d: got (%0d,%0d), want (%0d,%0d)", i, wq_x[i], wq_y[i], ex_x[i], ex_y[i]);
      end
    end
  endtask

  task automatic test_steep;
    int hx[$], hy[$];
    hx = '{0, 0, 1, 1, 2, 2}; hy = '{0, 1, 2, 3, 4, 5};
    model(0, 0, 2, 5);
    start_line(0, 0, 2, 5);
    collect(0, 30, -1);
    total++;
    if (timed_out || wq_x.size() != 6 || ex_x.size() != 6 || done_cyc != 6) begin
      bad++; $display("FAIL steep_count: writes=%0d model=%0d done=%0d, want 6 6 6", wq_x.size(), ex_x.size(), done_cyc);
    end
    for (int i = 0; i < 6 && i < wq_x.size() && i < ex_x.size(); i++) begin
      total++;
      if (wq_x[i] != hx[i] || wq_y[i] != hy[i] || wq_x[i] != ex_x[i] || wq_y[i] != ex_y[i]) begin
        bad++; $display("FAIL steep_pix%0d: got (%0d,%0d), want (%0d,%0d)", i, wq_x[i], wq_y[i], hx[i], hy[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    start_line(0, 0, 3, 3);
    collect(1, 40, -1);
    total++;
    if (stall_bad != 0) begin
      bad++; $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stall_bad);
    end
    total++;
    if (timed_out || wq_x.size() != 4 || done_cyc != 10) begin
      bad++; $display("FAIL bp_count: writes=%0d done=%0d to=%0b, want 4 10 0", wq_x.size(), done_cyc, timed_out);
    end
    for (int i = 0; i < 4 && i < wq_x.size(); i++) begin
      total++;
      if (wq_x[i] != i || wq_y[i] != i) begin
        bad++; $display("FAIL bp_pix%0d: got (%0d,%0d), want (%0d,%0d)", i, wq_x[i], wq_y[i], i, i);
      end
    end
  endtask

  task automatic test_busy_start;
    int extra;
    start_line(20, 10, 24, 10);
    collect(0, 30, 2);
    total++;
    if (timed_out || wq_x.size() != 5 || wq_x[0] != 20 || wq_x[4] != 24 || wq_y[4] != 10) begin
      bad++; $display("FAIL busy_line: writes=%0d to=%0b, want 5 writes 20..24 y=10", wq_x.size(), timed_out);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fb_write !== 1'b0 || ready !== 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL busy_queued: %0d active cycles after line, want 0", extra);
    end
  endtask

  task automatic test_reset_midline;
    int after;
    start_line(0, 0, 9, 0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (fb_write !== 1'b0 || ready !== 1'b1 || fb_x !== 10'd0) begin
      bad++; $display("FAIL async_reset: fb_write=%b ready=%b fb_x=%0d, want 0 1 0", fb_write, ready, fb_x);
    end
    @(negedge clk); rst_n = 1'b1;
    after = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (fb_write !== 1'b0) after++;
    end
    total++;
    if (after != 0) begin
      bad++; $display("FAIL reset_abandon: %0d write cycles after reset, want 0", after);
    end
  endtask

  task automatic test_back_to_back;
    int hx[$], hy[$];
    start_line(2, 8, 2, 4);
    collect(0, 20, -1);
    hx = '{2, 2, 2, 2, 2}; hy = '{8, 7, 6, 5, 4};
    total++;
    if (timed_out || wq_x.size() != 5) begin
      bad++; $display("FAIL vert_count: writes=%0d, want 5", wq_x.size());
    end
    for (int i = 0; i < 5 && i < wq_x.size(); i++) begin
      total++;
      if (wq_x[i] != hx[i] || wq_y[i] != hy[i]) begin
        bad++; $display("FAIL vert_pix%0d: got (%0d,%0d), want (%0d,%0d)", i, wq_x[i], wq_y[i], hx[i], hy[i]);
      end
    end
    // Start in the very first IDLE cycle after the previous line.
    start_line(4, 4, 1, 7);
    collect(0, 20, -1);
    hx = '{4, 3, 2, 1}; hy = '{4, 5, 6, 7};
    total++;
    if (timed_out || wq_x.size() != 4 || first_cyc != 0) begin
      bad++; $display("FAIL b2b_count: writes=%0d first=%0d, want 4 0", wq_x.size(), first_cyc);
    end
    for (int i = 0; i < 4 && i < wq_x.size(); i++) begin
      total++;
      if (wq_x[i] != hx[i] || wq_y[i] != hy[i]) begin
        bad++; $display("FAIL diag45_pix%0d: got (%0d,%0d), want (%0d,%0d)", i, wq_x[i], wq_y[i], hx[i], hy[i]);
      end
    end
  endtask

  task automatic test_full_diagonal;
    int errs;
    model(639, 0, 0, 479);
    start_line(639, 0, 0, 479);
    collect(0, 700, -1);
    total++;
    if (timed_out || wq_x.size() != 640 || done_cyc != 640) begin
      bad++; $display("FAIL diag_count: writes=%0d done=%0d to=%0b, want 640 640 0", wq_x.size(), done_cyc, timed_out);
    end
    total++;
    if (wq_x.size() == 0 || wq_x[wq_x.size()-1] != 0 || wq_y[wq_y.size()-1] != 479) begin
      bad++; $display("FAIL diag_last: writes=%0d, want last (0,479)", wq_x.size());
    end
    total++;
    if (oob != 0) begin
      bad++; $display("FAIL diag_bounds: %0d off-screen writes, want 0", oob);
    end
    errs = 0;
    for (int i = 0; i < wq_x.size() && i < ex_x.size(); i++)
      if (wq_x[i] != ex_x[i] || wq_y[i] != ex_y[i]) errs++;
    total++;
    if (errs != 0 || ex_x.size() != 640) begin
      bad++; $display("FAIL diag_model: %0d pixel differences (model len %0d), want 0 (640)", errs, ex_x.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_horizontal;
    test_steep;
    test_backpressure;
    test_busy_start;
    test_reset_midline;
    test_back_to_back;
    test_full_diagonal;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
Rasterises one straight line segment into individual pixel writes using integer Bresenham stepping. It sits directly downstream of the plotting controller: it consumes the endpoint pair (x1,y1)-(x2,y2) with a start/ready handshake, and emits one framebuffer write per pixel. Writes go to the framebuffer writer through a valid/ready handshake, so the framebuffer can stall rasterisation.

Parameters:
HOR_ACTIVE_PIXELS, 640, screen width; X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)
VER_ACTIVE_PIXELS, 480, screen height; Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request to draw; sampled only while ready=1
ready  output  1  high in IDLE only
x1  input  X_WIDTH  start point x; sampled with start
y1  input  Y_WIDTH  start point y; sampled with start
x2  input  X_WIDTH  end point x; sampled with start
y2  input  Y_WIDTH  end point y; sampled with start
fb_x  output  X_WIDTH  pixel x of the current write
fb_y  output  Y_WIDTH  pixel y of the current write
fb_write  output  1  pixel write valid
fb_ready  input  1  framebuffer accepts the write this cycle

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ready=1; fb_write=0; fb_x=0; fb_y=0; all internal registers cleared. Any line in progress is abandoned and no further writes are issued.
- States:
  - IDLE -> INIT on start=1. The cycle start is sampled, x1/y1/x2/y2 are latched. start while not ready is ignored, not queued.
  - INIT (1 cycle) computes the stepping terms:
    - dx = |x2-x1|, dy = -|y2-y1|
    - sx = +1 if x1<x2 else -1; sy = +1 if y1<y2 else -1
    - err = dx+dy; cur = (x1,y1)
    - Then -> PLOT.
  - PLOT: fb_write=1 with fb_x/fb_y = cur.
    - fb_write and fb_x/fb_y are held stable until fb_ready=1.
    - On an accepted write (fb_write & fb_ready), if cur == (x2,y2): -> IDLE, and fb_write drops next cycle.
    - Otherwise, with e2 = 2*err computed from the pre-update err:
      - if e2 >= dy: err += dy, cur.x += sx
      - if e2 <= dx: err += dx, cur.y += sy
      - Both updates apply in the same cycle when both conditions hold.
- Arithmetic: dx, dy, err and e2 are signed, width max(X_WIDTH,Y_WIDTH)+2, with no overflow for any on-screen endpoints. Coordinates are unsigned and never leave the bounding box of the two endpoints.
- Latency and throughput:
  - start accepted at edge T gives INIT at T+1 and the first fb_write=1 from T+2.
  - With fb_ready held high, there is one pixel per cycle.
  - A line writes exactly max(|x2-x1|,|y2-y1|)+1 pixels, first (x1,y1), last (x2,y2), each pixel exactly once.
  - ready returns high the cycle after the last accepted write.
- Degenerate cases:
  - x1==x2 and y1==y2: exactly one write.
  - Horizontal, vertical and 45-degree lines in all four directions are supported, as are endpoints on screen edges (0 and max).
- fb_ready asserted while fb_write=0 has no effect.
- A back-to-back start in the first IDLE cycle after a line is accepted normally.

Test Plan:
1. Single point: start with (5,7)-(5,7), fb_ready=1 -> exactly one write (5,7) at T+2; ready high at T+3.
2. Horizontal, reversed: (10,3)-(6,3) -> writes x=10,9,8,7,6 with y=3, one per cycle, 5 writes total.
3. Steep line: (0,0)-(2,5) -> 6 writes (0,0),(0,1),(1,2),(1,3),(2,4),(2,5). Check against a software Bresenham model.
4. Backpressure: (0,0)-(3,3) with fb_ready toggling 1,0,0,1,... -> fb_x/fb_y/fb_write held stable while stalled; exactly 4 writes (0,0),(1,1),(2,2),(3,3).
5. Busy start and reset: pulse start with new endpoints mid-line -> ignored, and the original line completes. Then drop rst_n mid-line -> fb_write=0 and ready=1 immediately (asynchronous), and no writes occur after rst_n rises.
6. Full-screen diagonal: (639,0)-(0,479) -> 640 writes, last write (0,479), no coordinate outside 0..639 / 0..479.
